// File: rtl/nand_counter.sv
// nand_counter: WIDTH-bit loadable up-counter built only from NAND2 cells.
// Ports: CLK, RST (sync, active-high), EN, LD, D[WIDTH], Q[WIDTH], TC.

// Two-input NAND: the only primitive in the gate library.
// Ports: a, b inputs; y = ~(a & b).
module NAND2 (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = ~(a & b);
endmodule

// Counter: per bit, a carry/XOR incrementer, a load mux, a reset gate
// and an edge-triggered three-latch flip-flop, all composed of NAND2.
// Priority of the next-state selection: RST, then LD, then EN, else hold.
// TC is the end of the EN-gated carry chain, i.e. EN & (&Q).
module nand_counter #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             LD,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             TC
);

   logic             rst_n;
   logic             ld_n;
   // cy[i] = EN & Q[0] & ... & Q[i-1]; gating the chain with EN makes
   // the XOR pass Q through unchanged when counting is disabled.
   logic [WIDTH:0]   cy;

   assign cy[0] = EN;
   assign TC    = cy[WIDTH];

   NAND2 u_rst_inv (.a(RST), .b(RST), .y(rst_n));
   NAND2 u_ld_inv  (.a(LD),  .b(LD),  .y(ld_n));

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic cy_n;
      logic x_b;
      logic x_c;
      logic inc;
      logic sel_ld;
      logic sel_inc;
      logic nxt;
      logic nxt_n;
      logic d_in;
      logic n1;
      logic n2;
      logic n3;
      logic n4;
      logic ck_n4_n;
      logic ck_n4;
      logic qb;

      // Carry: cy_n doubles as the first gate of the 4-NAND XOR.
      NAND2 u_cy_n (.a(Q[i]),  .b(cy[i]), .y(cy_n));
      NAND2 u_cy   (.a(cy_n),  .b(cy_n),  .y(cy[i+1]));

      // inc = Q[i] ^ cy[i]
      NAND2 u_xb   (.a(Q[i]),  .b(cy_n),  .y(x_b));
      NAND2 u_xc   (.a(cy[i]), .b(cy_n),  .y(x_c));
      NAND2 u_xo   (.a(x_b),   .b(x_c),   .y(inc));

      // nxt = LD ? D[i] : inc
      NAND2 u_m_ld (.a(LD),    .b(D[i]),  .y(sel_ld));
      NAND2 u_m_in (.a(ld_n),  .b(inc),   .y(sel_inc));
      NAND2 u_m_o  (.a(sel_ld),.b(sel_inc),.y(nxt));

      // d_in = ~RST & nxt: reset acts by forcing the flop input low.
      NAND2 u_r_n  (.a(rst_n), .b(nxt),   .y(nxt_n));
      NAND2 u_r_o  (.a(nxt_n), .b(nxt_n), .y(d_in));

      // Edge-triggered flop. n1/n2 and n3/n4 are the input latches,
      // Q/qb the output latch. The classic three-input gate
      // n3 = ~(n2 & CLK & n4) is composed from NAND2 so that, with
      // zero-delay gates, n3 cannot glitch low on a rising edge that
      // captures a 1, and stays locked while CLK is high even though
      // d_in moves as soon as Q updates.
      NAND2 u_f1   (.a(n4),    .b(n2),    .y(n1));
      NAND2 u_f2   (.a(n1),    .b(CLK),   .y(n2));
      NAND2 u_f3a  (.a(CLK),   .b(n4),    .y(ck_n4_n));
      NAND2 u_f3b  (.a(ck_n4_n),.b(ck_n4_n),.y(ck_n4));
      NAND2 u_f3   (.a(n2),    .b(ck_n4), .y(n3));
      NAND2 u_f4   (.a(n3),    .b(d_in),  .y(n4));
      NAND2 u_f5   (.a(n2),    .b(qb),    .y(Q[i]));
      NAND2 u_f6   (.a(Q[i]),  .b(n3),    .y(qb));
   end

endmodule

// File: tb/tb_nand_counter.sv
// Testbench for nand_counter: widths 4, 1 and 8 checked against an
// integer reference model of load/count/reset behaviour.
module tb_nand_counter;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       EN  = 1'b0;
   logic       LD  = 1'b0;
   logic [3:0] d4  = '0;
   logic [0:0] d1  = '0;
   logic [7:0] d8  = '0;
   logic [3:0] q4;
   logic [0:0] q1;
   logic [7:0] q8;
   logic       tc4;
   logic       tc1;
   logic       tc8;

   int e4 = 0;
   int e1 = 0;
   int e8 = 0;
   int n_pass = 0;
   int n_total = 0;

   always #5 CLK = ~CLK;

   nand_counter #(.WIDTH(4)) dut4 (
      .CLK(CLK), .RST(RST), .EN(EN), .LD(LD), .D(d4), .Q(q4), .TC(tc4));
   nand_counter #(.WIDTH(1)) dut1 (
      .CLK(CLK), .RST(RST), .EN(EN), .LD(LD), .D(d1), .Q(q1), .TC(tc1));
   nand_counter #(.WIDTH(8)) dut8 (
      .CLK(CLK), .RST(RST), .EN(EN), .LD(LD), .D(d8), .Q(q8), .TC(tc8));

   function automatic int mdl(int cur, int w, logic r, logic l,
                              logic e, int d);
      if (r) return 0;
      if (l) return d;
      if (e) return (cur + 1) % (1 << w);
      return cur;
   endfunction

   // Apply one rising edge to the model, then return on the falling edge.
   task automatic cycle();
      @(posedge CLK);
      e4 = mdl(e4, 4, RST, LD, EN, int'(d4));
      e1 = mdl(e1, 1, RST, LD, EN, int'(d1));
      e8 = mdl(e8, 8, RST, LD, EN, int'(d8));
      @(negedge CLK);
   endtask

   task automatic test_reset();
      RST = 1; EN = 1; LD = 1; d4 = 4'hA; d1 = 1'b1; d8 = 8'hA5;
      for (int k = 0; k < 2; k++) begin
         cycle();
         n_total++;
         if (q4 !== 4'h0) $display("FAIL reset_q4 edge%0d got %h want 0", k, q4);
         else n_pass++;
         n_total++;
         if (tc4 !== 1'b0) $display("FAIL reset_tc4 got %b want 0", tc4);
         else n_pass++;
      end
      RST = 0; LD = 0; EN = 0;
   endtask

   task automatic test_count_wrap();
      int tcs;
      tcs = 0;
      RST = 1; cycle(); RST = 0; EN = 1;
      for (int k = 0; k < 17; k++) begin
         cycle();
         if (tc4) tcs++;
         n_total++;
         if (q4 !== 4'(e4)) $display("FAIL wrap_q step%0d got %0d want %0d", k, q4, e4);
         else n_pass++;
         n_total++;
         if (tc4 !== (e4 == 15)) $display("FAIL wrap_tc step%0d got %b want %b", k, tc4, e4 == 15);
         else n_pass++;
      end
      n_total++;
      if (tcs != 1) $display("FAIL wrap_tc_count got %0d want 1", tcs);
      else n_pass++;
      EN = 0;
   endtask

   task automatic test_load_priority();
      LD = 1; d4 = 4'h3; cycle();
      LD = 1; EN = 1; d4 = 4'hC; cycle();
      n_total++;
      if (q4 !== 4'd12) $display("FAIL ld_prio got %0d want 12", q4);
      else n_pass++;
      LD = 0; cycle();
      n_total++;
      if (q4 !== 4'd13) $display("FAIL ld_then_inc got %0d want 13", q4);
      else n_pass++;
      EN = 0;
   endtask

   task automatic test_hold_tc();
      LD = 1; d4 = 4'hF; cycle(); LD = 0; EN = 0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         n_total++;
         if (q4 !== 4'hF || tc4 !== 1'b0)
            $display("FAIL hold q=%0d tc=%b want q=15 tc=0", q4, tc4);
         else n_pass++;
      end
      EN = 1; #1;
      n_total++;
      if (tc4 !== 1'b1) $display("FAIL tc_comb got %b want 1", tc4);
      else n_pass++;
      cycle();
      n_total++;
      if (q4 !== 4'h0 || tc4 !== 1'b0)
         $display("FAIL hold_wrap q=%0d tc=%b want q=0 tc=0", q4, tc4);
      else n_pass++;
      EN = 0;
   endtask

   task automatic test_mid_reset();
      RST = 1; cycle(); RST = 0; EN = 1;
      for (int k = 0; k < 9; k++) cycle();
      n_total++;
      if (q4 !== 4'd9) $display("FAIL mid_pre got %0d want 9", q4);
      else n_pass++;
      RST = 1; cycle(); RST = 0;
      n_total++;
      if (q4 !== 4'd0) $display("FAIL mid_rst got %0d want 0", q4);
      else n_pass++;
      cycle();
      n_total++;
      if (q4 !== 4'd1) $display("FAIL mid_resume got %0d want 1", q4);
      else n_pass++;
      EN = 0;
   endtask

   task automatic test_width_sweep();
      int tcs;
      tcs = 0;
      RST = 1; EN = 1; LD = 0; cycle(); RST = 0;
      for (int k = 0; k < 256; k++) begin
         cycle();
         if (tc8) tcs++;
         n_total++;
         if (q1 !== 1'(e1) || tc1 !== (e1 == 1))
            $display("FAIL w1 step%0d q=%b tc=%b want q=%0d tc=%b", k, q1, tc1, e1, e1 == 1);
         else n_pass++;
         n_total++;
         if (q8 !== 8'(e8)) $display("FAIL w8 step%0d got %0d want %0d", k, q8, e8);
         else n_pass++;
      end
      n_total++;
      if (q8 !== 8'd0 || tcs != 1)
         $display("FAIL w8_wrap q=%0d tc_count=%0d want q=0 tc_count=1", q8, tcs);
      else n_pass++;
      EN = 0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 300; k++) begin
         RST = ($urandom_range(0, 19) == 0);
         LD  = ($urandom_range(0, 5) == 0);
         EN  = ($urandom_range(0, 3) != 0);
         d4  = 4'($urandom);
         d1  = 1'($urandom);
         d8  = 8'($urandom);
         cycle();
         n_total++;
         if (q4 !== 4'(e4) || tc4 !== (EN && e4 == 15))
            $display("FAIL rnd4 cyc%0d q=%0d tc=%b want q=%0d", k, q4, tc4, e4);
         else n_pass++;
         n_total++;
         if (q1 !== 1'(e1) || tc1 !== (EN && e1 == 1))
            $display("FAIL rnd1 cyc%0d q=%0d tc=%b want q=%0d", k, q1, tc1, e1);
         else n_pass++;
         n_total++;
         if (q8 !== 8'(e8) || tc8 !== (EN && e8 == 255))
            $display("FAIL rnd8 cyc%0d q=%0d tc=%b want q=%0d", k, q8, tc8, e8);
         else n_pass++;
      end
   endtask

   initial begin
      @(negedge CLK);
      test_reset();
      test_count_wrap();
      test_load_priority();
      test_hold_tc();
      test_mid_reset();
      test_width_sweep();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
